wgc_move_sequencer: RTL and testbench
=====================================

Name: wgc_move_sequencer

Overview:
Upstream command stage for the wolf_goat_cabbage puzzle core. Accepts encoded move requests over a valid/ready handshake and buffers them in a small FIFO. Checks each move against a shadow copy of the bank state and issues only legal, safe moves to the core as one-hot w/g/c strobes with move_valid. Also reports rejections, solved status and FIFO occupancy.

Parameters:
DEPTH, 4, FIFO entries; power of two, minimum 2.
CW, $clog2(DEPTH+1), width of the count output (derived, not overridden).

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  move request valid
req_ready  output  1  FIFO can accept; equals !full
req_move  input  2  0=farmer alone, 1=wolf, 2=goat, 3=cabbage
move_valid  output  1  issued move present to core
move_ready  input  1  core accepts move this cycle
w  output  1  wolf crosses with farmer (to core .w)
g  output  1  goat crosses (to core .g)
c  output  1  cabbage crosses (to core .c)
bank_m, bank_w, bank_g, bank_c  output  1 each  shadow banks, 0=start, 1=far
reject  output  1  one-cycle pulse, popped request discarded
reject_code  output  2  1=passenger not with farmer, 2=unsafe result, 3=already solved; held until next reject
solved  output  1  all four banks = 1
count  output  CW  FIFO occupancy

Behaviour:
- Reset (async assert, sync release): FIFO empty, count=0, req_ready=1, move_valid=0, w=g=c=0, all banks=0, reject=0, reject_code=0, solved=0.
- Push: req_valid && req_ready at edge N writes the entry. Full FIFO stalls push. No bypass: an empty FIFO gives req_ready=1 and a push is never lost.
- States: IDLE (no move held), HOLD (move_valid=1, waiting for move_ready), DONE (solved).
- IDLE, FIFO non-empty: pop the head at the edge and evaluate it against the shadow banks.
  - Legal and safe: register move_valid=1, assert exactly one of w/g/c (none for farmer alone), go to HOLD.
  - Otherwise: reject=1 for one cycle, set reject_code, stay IDLE.
  - Latency: entry pushed at edge N gives move_valid/reject at the earliest after edge N+1.
- Reject code 1: passenger bank != bank_m.
- Reject code 2: resulting state has wolf==goat!=farmer or goat==cabbage!=farmer.
- HOLD: outputs stable while move_valid && !move_ready. On move_valid && move_ready at an edge:
  - toggle bank_m and the passenger bank, clear move_valid and w/g/c;
  - go to DONE if all banks become 1, else IDLE.
  - No pop during HOLD; the next move issues at the earliest one cycle after the handshake.
- DONE: solved=1. Each popped entry is rejected with code 3, one per cycle. Banks frozen.
- Simultaneous push and pop when full: pop happens and push is refused, since req_ready was 0 that cycle.
- FIFO read/write pointers wrap modulo DEPTH. count tracks exactly: +1 on push only, -1 on pop only, unchanged on both.
- Reset asserted mid-HOLD: move_valid drops immediately, FIFO contents discarded, banks return to 0.
- Invariant: at most one of w/g/c is high, and w/g/c are zero whenever move_valid=0.

Optional Feature:
WGC_ALLOW_UNSAFE_EN
- Defined: unsafe moves are issued rather than rejected, so code 2 never occurs. An extra output unsafe (1 bit) goes high sticky after the handshake of any move that leaves an unsafe state. It clears only on reset.
- Undefined: unsafe port absent; unsafe moves rejected with code 2 as above.

Test Plan:
- Classic solution, move_ready=1: push goat, alone, wolf, goat, cabbage, alone, goat -> seven move_valid handshakes with strobes g,-,w,g,c,-,g; after the 7th, banks=1111 and solved=1; reject never pulses.
- From reset push wolf -> reject=1, reject_code=2, no move_valid, banks stay 0000.
- Push goat, alone, goat -> first two issue; third: goat=1, farmer=0 -> reject_code=1, banks m=0 g=1.
- move_ready=0, push 5 requests -> first popped into HOLD, count reaches 4, req_ready=0. Raise move_ready -> moves drain in order, count decrements to 0.
- After the solved sequence push alone -> reject_code=3, banks stay 1111, solved stays 1.
- rst_n low for 1 cycle while in HOLD with count=2 -> move_valid=0, count=0, banks 0000 immediately; a fresh goat request then issues normally.

Source files
------------

// File: rtl/wgc_move_sequencer_if.sv
// ---------------------------------------------------------------------------
// wgc_move_sequencer_if
// Groups the two handshake channels of the move sequencer:
//   request channel : req_valid, req_move[1:0] (to sequencer), req_ready (from)
//   issue channel   : move_valid, w, g, c (from sequencer), move_ready (to)
// Modports:
//   master : the side that produces requests and consumes issued moves
//   slave  : the sequencer itself
// ---------------------------------------------------------------------------
interface wgc_move_sequencer_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_move;
  logic       move_valid;
  logic       move_ready;
  logic       w;
  logic       g;
  logic       c;

  modport master (
    output req_valid, req_move, move_ready,
    input  req_ready, move_valid, w, g, c
  );

  modport slave (
    input  req_valid, req_move, move_ready,
    output req_ready, move_valid, w, g, c
  );
endinterface

// File: rtl/wgc_move_sequencer.sv
// ---------------------------------------------------------------------------
// wgc_move_sequencer
// Command stage in front of the wolf/goat/cabbage puzzle core. Move requests
// are queued in a DEPTH-entry FIFO, checked against a shadow copy of the bank
// state and only legal, safe moves are issued as one-hot w/g/c strobes.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   bus (slave)         request channel (req_valid/req_ready/req_move) and
//                       issue channel (move_valid/move_ready/w/g/c)
//   bank_m/w/g/c        shadow banks, 0 = start side, 1 = far side
//   reject, reject_code one-cycle discard pulse; code held until next reject
//                       (1 passenger not with farmer, 2 unsafe, 3 solved)
//   solved              all four banks on the far side
//   count               FIFO occupancy
//   unsafe              (only with WGC_ALLOW_UNSAFE_EN) sticky flag set when
//                       a completed move leaves an unsafe state
//
// Build option: define WGC_ALLOW_UNSAFE_EN to issue unsafe moves instead of
// rejecting them; the unsafe output then exists.
// ---------------------------------------------------------------------------
module wgc_move_sequencer #(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wgc_move_sequencer_if.slave  bus,
  output logic                 bank_m,
  output logic                 bank_w,
  output logic                 bank_g,
  output logic                 bank_c,
  output logic                 reject,
  output logic [1:0]           reject_code,
  output logic                 solved,
  output logic [CW-1:0]        count
`ifdef WGC_ALLOW_UNSAFE_EN
  ,
  output logic                 unsafe
`endif
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0]  ONE_CNT  = CW'(1);
  localparam logic [CW-1:0]  ZERO_CNT = CW'(0);

  // Bank vectors are packed {m, w, g, c}; move codes 1..3 pick w, g, c.

  // Bank vector after a move: farmer always crosses, passenger with him.
  function automatic logic [3:0] apply_move(input logic [1:0] mv, input logic [3:0] b);
    logic [3:0] r;
    r    = b;
    r[3] = ~b[3];
    case (mv)
      2'd1:    r[2] = ~b[2];
      2'd2:    r[1] = ~b[1];
      2'd3:    r[0] = ~b[0];
      default: r[3] = ~b[3];
    endcase
    return r;
  endfunction

  // A passenger can only cross from the farmer's bank.
  function automatic logic passenger_ok(input logic [1:0] mv, input logic [3:0] b);
    logic ok;
    case (mv)
      2'd1:    ok = (b[2] == b[3]);
      2'd2:    ok = (b[1] == b[3]);
      2'd3:    ok = (b[0] == b[3]);
      default: ok = 1'b1;
    endcase
    return ok;
  endfunction

  // Something gets eaten when goat is left with wolf or cabbage unattended.
  function automatic logic is_unsafe(input logic [3:0] b);
    return ((b[2] == b[1]) && (b[1] != b[3])) ||
           ((b[1] == b[0]) && (b[1] != b[3]));
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_r;
  logic [1:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          req_ready_r;
  logic          move_valid_r;
  logic          w_r;
  logic          g_r;
  logic          c_r;
  logic [1:0]    mv_r;
  logic          bank_m_r;
  logic          bank_w_r;
  logic          bank_g_r;
  logic          bank_c_r;
  logic          reject_r;
  logic [1:0]    reject_code_r;
  logic          solved_r;
`ifdef WGC_ALLOW_UNSAFE_EN
  logic          unsafe_r;
`endif

  logic          push_s;
  logic          pop_s;
  logic [1:0]    head_s;
  logic          head_ok_s;
  logic [3:0]    banks_s;
  logic [3:0]    head_next_s;
  logic [3:0]    hold_next_s;
  logic [CW-1:0] count_nxt_s;

  assign banks_s = {bank_m_r, bank_w_r, bank_g_r, bank_c_r};

  // Push/pop decode, head evaluation and next occupancy.
  always_comb begin
    push_s = bus.req_valid & req_ready_r;
    if (((state_r == ST_IDLE) || (state_r == ST_DONE)) && (count_r != ZERO_CNT)) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
    head_s      = mem_r[rd_ptr_r];
    head_ok_s   = passenger_ok(head_s, banks_s);
    head_next_s = apply_move(head_s, banks_s);
    hold_next_s = apply_move(mv_r, banks_s);
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + ONE_CNT;
      2'b01:   count_nxt_s = count_r - ONE_CNT;
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO storage, pointers and occupancy; req_ready registered from next count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 2'b00;
      end
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= ZERO_CNT;
      req_ready_r <= 1'b1;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= bus.req_move;
        wr_ptr_r        <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      count_r     <= count_nxt_s;
      req_ready_r <= (count_nxt_s != FULL_CNT);
    end
  end

  // Sequencer FSM: evaluate popped moves, hold issued move, track shadow banks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      move_valid_r  <= 1'b0;
      w_r           <= 1'b0;
      g_r           <= 1'b0;
      c_r           <= 1'b0;
      mv_r          <= 2'd0;
      bank_m_r      <= 1'b0;
      bank_w_r      <= 1'b0;
      bank_g_r      <= 1'b0;
      bank_c_r      <= 1'b0;
      reject_r      <= 1'b0;
      reject_code_r <= 2'd0;
      solved_r      <= 1'b0;
`ifdef WGC_ALLOW_UNSAFE_EN
      unsafe_r      <= 1'b0;
`endif
    end else begin
      reject_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            if (!head_ok_s) begin
              reject_r      <= 1'b1;
              reject_code_r <= 2'd1;
`ifndef WGC_ALLOW_UNSAFE_EN
            end else if (is_unsafe(head_next_s)) begin
              reject_r      <= 1'b1;
              reject_code_r <= 2'd2;
`endif
            end else begin
              move_valid_r <= 1'b1;
              mv_r         <= head_s;
              w_r          <= (head_s == 2'd1);
              g_r          <= (head_s == 2'd2);
              c_r          <= (head_s == 2'd3);
              state_r      <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (bus.move_ready) begin
            {bank_m_r, bank_w_r, bank_g_r, bank_c_r} <= hold_next_s;
            move_valid_r <= 1'b0;
            w_r          <= 1'b0;
            g_r          <= 1'b0;
            c_r          <= 1'b0;
            solved_r     <= &hold_next_s;
            state_r      <= (&hold_next_s) ? ST_DONE : ST_IDLE;
`ifdef WGC_ALLOW_UNSAFE_EN
            unsafe_r     <= unsafe_r | is_unsafe(hold_next_s);
`endif
          end
        end
        ST_DONE: begin
          // Puzzle finished: banks frozen, every request is discarded.
          if (pop_s) begin
            reject_r      <= 1'b1;
            reject_code_r <= 2'd3;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          move_valid_r <= 1'b0;
          w_r          <= 1'b0;
          g_r          <= 1'b0;
          c_r          <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_r;
  assign bus.move_valid = move_valid_r;
  assign bus.w          = w_r;
  assign bus.g          = g_r;
  assign bus.c          = c_r;
  assign bank_m         = bank_m_r;
  assign bank_w         = bank_w_r;
  assign bank_g         = bank_g_r;
  assign bank_c         = bank_c_r;
  assign reject         = reject_r;
  assign reject_code    = reject_code_r;
  assign solved         = solved_r;
  assign count          = count_r;
`ifdef WGC_ALLOW_UNSAFE_EN
  assign unsafe         = unsafe_r;
`endif

endmodule

// File: tb/tb_wgc_move_sequencer.sv
// ---------------------------------------------------------------------------
// tb_wgc_move_sequencer
// Directed stimulus against wgc_move_sequencer. A puzzle-level model (request
// queue, positions of farmer/wolf/goat/cabbage, the move being held) predicts
// every output; a negedge process compares all outputs each cycle, and
// hand-computed literals pin the model at key points.
// ---------------------------------------------------------------------------
module tb_wgc_move_sequencer;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst_n;
  logic          bank_m, bank_w, bank_g, bank_c;
  logic          reject;
  logic [1:0]    reject_code;
  logic          solved;
  logic [CW-1:0] count;
`ifdef WGC_ALLOW_UNSAFE_EN
  logic          unsafe;
`endif

  wgc_move_sequencer_if bus_if();

  wgc_move_sequencer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus_if),
    .bank_m      (bank_m),
    .bank_w      (bank_w),
    .bank_g      (bank_g),
    .bank_c      (bank_c),
    .reject      (reject),
    .reject_code (reject_code),
    .solved      (solved),
    .count       (count)
`ifdef WGC_ALLOW_UNSAFE_EN
    ,
    .unsafe      (unsafe)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Model: pos[0]=farmer, pos[1]=wolf, pos[2]=goat, pos[3]=cabbage.
  int mq[$];
  int pos[4];
  int held;
  bit m_rej;
  int m_code;
  bit m_solved;
  bit m_unsafe;
  bit chk_en = 1'b0;

  int hs_cnt  = 0;
  int rej_cnt = 0;
  int strobes[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 4; i++) pos[i] = 0;
    held     = -1;
    m_rej    = 1'b0;
    m_code   = 0;
    m_solved = 1'b0;
    m_unsafe = 1'b0;
  endtask

  function automatic bit eaten(input int p0, input int p1, input int p2, input int p3);
    return ((p1 == p2) && (p2 != p0)) || ((p2 == p3) && (p2 != p0));
  endfunction

  // One clock edge of the puzzle-level behaviour, using the inputs seen at it.
  task automatic model_edge();
    bit room;
    int mv;
    int np[4];
    room  = (mq.size() < DEPTH);
    m_rej = 1'b0;
    if (held >= 0) begin
      if (bus_if.move_ready) begin
        pos[0] = 1 - pos[0];
        if (held != 0) pos[held] = 1 - pos[held];
        if (eaten(pos[0], pos[1], pos[2], pos[3])) m_unsafe = 1'b1;
        if (pos[0] + pos[1] + pos[2] + pos[3] == 4) m_solved = 1'b1;
        held = -1;
      end
    end else if (mq.size() > 0) begin
      mv = mq.pop_front();
      np = pos;
      np[0] = 1 - np[0];
      if (mv != 0) np[mv] = 1 - np[mv];
      if (m_solved) begin
        m_rej = 1'b1; m_code = 3;
      end else if (mv != 0 && pos[mv] != pos[0]) begin
        m_rej = 1'b1; m_code = 1;
`ifndef WGC_ALLOW_UNSAFE_EN
      end else if (eaten(np[0], np[1], np[2], np[3])) begin
        m_rej = 1'b1; m_code = 2;
`endif
      end else begin
        held = mv;
      end
    end
    if (bus_if.req_valid && room) mq.push_back(int'(bus_if.req_move));
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic push(input int mv);
    bus_if.req_valid = 1'b1;
    bus_if.req_move  = mv[1:0];
    step();
    bus_if.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 40;
    while ((mq.size() > 0 || held >= 0) && budget > 0) begin
      step();
      budget--;
    end
    if (budget == 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_idle at %0t: got timeout, expected drain", $time);
    end
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    step();
    rst_n = 1'b1;
  endtask

  // Every-cycle compare against the model, plus handshake/reject monitors.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready",   bus_if.req_ready,  (mq.size() < DEPTH));
      chk("count",       count,             mq.size());
      chk("move_valid",  bus_if.move_valid, (held >= 0));
      chk("w",           bus_if.w,          (held == 1));
      chk("g",           bus_if.g,          (held == 2));
      chk("c",           bus_if.c,          (held == 3));
      chk("banks",       {bank_m, bank_w, bank_g, bank_c},
          {pos[0][0], pos[1][0], pos[2][0], pos[3][0]});
      chk("reject",      reject,            m_rej);
      chk("reject_code", reject_code,       m_code);
      chk("solved",      solved,            m_solved);
`ifdef WGC_ALLOW_UNSAFE_EN
      chk("unsafe",      unsafe,            m_unsafe);
`endif
      if (rst_n && bus_if.move_valid && bus_if.move_ready) begin
        hs_cnt++;
        strobes.push_back(bus_if.w ? 1 : bus_if.g ? 2 : bus_if.c ? 3 : 0);
      end
      if (reject) rej_cnt++;
    end
  end

  initial begin
    int classic[7];
    int hs0, rj0;
    classic = '{2, 0, 1, 2, 3, 0, 2};
    bus_if.req_valid  = 1'b0;
    bus_if.req_move   = 2'd0;
    bus_if.move_ready = 1'b1;
    rst_n = 1'b0;
    model_reset();
    step();
    step();
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Reset state, literal.
    chk("rst_req_ready", bus_if.req_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_banks", {bank_m, bank_w, bank_g, bank_c}, 4'b0000);
    chk("rst_move_valid", bus_if.move_valid, 0);

    // Classic seven-move solution with move_ready held high.
    for (int i = 0; i < 7; i++) push(classic[i]);
    wait_idle();
    chk("classic_hs", hs_cnt, 7);
    chk("classic_rej", rej_cnt, 0);
    for (int i = 0; i < 7; i++) begin
      chk("classic_strobe", (i < strobes.size()) ? strobes[i] : -1, classic[i]);
    end
    chk("classic_banks", {bank_m, bank_w, bank_g, bank_c}, 4'b1111);
    chk("classic_solved", solved, 1);

    // Requests after solving are discarded with code 3.
    rj0 = rej_cnt;
    push(0);
    push(1);
    wait_idle();
    chk("done_code", reject_code, 3);
    chk("done_rej", rej_cnt - rj0, 2);
    chk("done_banks", {bank_m, bank_w, bank_g, bank_c}, 4'b1111);
    chk("done_solved", solved, 1);

`ifndef WGC_ALLOW_UNSAFE_EN
    // Wolf first leaves goat with cabbage.
    do_reset();
    rj0 = rej_cnt;
    hs0 = hs_cnt;
    push(1);
    wait_idle();
    chk("wolf_code", reject_code, 2);
    chk("wolf_rej", rej_cnt - rj0, 1);
    chk("wolf_hs", hs_cnt - hs0, 0);
    chk("wolf_banks", {bank_m, bank_w, bank_g, bank_c}, 4'b0000);
`endif

    // Goat, alone, goat: the goat is no longer with the farmer.
    do_reset();
    hs0 = hs_cnt;
    push(2);
    push(0);
    push(2);
    wait_idle();
    chk("gag_hs", hs_cnt - hs0, 2);
    chk("gag_code", reject_code, 1);
    chk("gag_bank_m", bank_m, 0);
    chk("gag_bank_g", bank_g, 1);

    // Backpressure: fill the FIFO behind a held move, then drain in order.
    do_reset();
    bus_if.move_ready = 1'b0;
    hs0 = hs_cnt;
    rj0 = rej_cnt;
    push(2);
    push(0);
    push(1);
    push(2);
    push(3);
    chk("bp_count", count, 4);
    chk("bp_ready", bus_if.req_ready, 0);
    chk("bp_hold_g", bus_if.g, 1);
    push(2);
    chk("bp_full_refused", count, 4);
    bus_if.move_ready = 1'b1;
    wait_idle();
    chk("bp_hs", hs_cnt - hs0, 5);
    chk("bp_rej", rej_cnt - rj0, 0);
    chk("bp_count_end", count, 0);
    chk("bp_banks", {bank_m, bank_w, bank_g, bank_c}, 4'b1101);

    // Reset while holding a move with two queued entries.
    do_reset();
    bus_if.move_ready = 1'b0;
    push(2);
    push(0);
    push(1);
    chk("mid_count", count, 2);
    chk("mid_hold", bus_if.move_valid, 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_move_valid", bus_if.move_valid, 0);
    chk("async_count", count, 0);
    chk("async_banks", {bank_m, bank_w, bank_g, bank_c}, 4'b0000);
    step();
    rst_n = 1'b1;
    bus_if.move_ready = 1'b1;
    hs0 = hs_cnt;
    push(2);
    wait_idle();
    chk("post_rst_hs", hs_cnt - hs0, 1);
    chk("post_rst_banks", {bank_m, bank_w, bank_g, bank_c}, 4'b1010);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
